mem_port_arbiter: RTL

- Shares the single data port of the 16-bit unified memory between two requesters: port 0 (CPU load/store path) and port 1 (program loader / debug access).
- Accepts one transaction at a time using a valid/ready handshake.
- Drives the memory address, write-data and save lines, and returns read data to the owning port with a one-cycle rvalid pulse.
- Sits between the logic sector / loader and the memory's data port.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the unified memory data port between
// port 0 (CPU) and port 1 (loader/debug), one transaction at a time.
module mem_port_arbiter #(
    parameter int ADDR_BITS      = 16,
    parameter int DATA_BITS      = 16,
    parameter int MEM_LATENCY    = 1,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req0_write,
    input  logic [ADDR_BITS-1:0] req0_addr,
    input  logic [DATA_BITS-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_rvalid,
    output logic [DATA_BITS-1:0] req0_rdata,
    input  logic                 req1_valid,
    input  logic                 req1_write,
    input  logic [ADDR_BITS-1:0] req1_addr,
    input  logic [DATA_BITS-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_rvalid,
    output logic [DATA_BITS-1:0] req1_rdata,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    output logic                 mem_save,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 busy
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [1:0] LAT = 2'(MEM_LATENCY);

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q, owner_d;
    logic                 write_q, write_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] rdata0_q, rdata0_d;
    logic [DATA_BITS-1:0] rdata1_q, rdata1_d;
    logic                 rvalid0_q, rvalid0_d;
    logic                 rvalid1_q, rvalid1_d;
    logic                 win0, win1;
    logic                 acc0, acc1;

    // winner: lone requester, else port 0 under fixed priority,
    // else the port that was not granted last
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIORITY != 0 || last_grant_q) begin
                win0 = 1'b1;
            end else begin
                win1 = 1'b1;
            end
        end else begin
            win0 = req0_valid;
            win1 = req1_valid;
        end
    end

    assign req0_ready  = rst && (state_q == S_IDLE) && win0;
    assign req1_ready  = rst && (state_q == S_IDLE) && win1;
    assign acc0        = req0_ready && req0_valid;
    assign acc1        = req1_ready && req1_valid;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q != S_IDLE);
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    // transaction FSM: latch on accept, issue, wait, return data
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        mem_save     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                unique case (1'b1)
                    acc0: begin
                        owner_d      = 1'b0;
                        last_grant_d = 1'b0;
                        write_d      = req0_write;
                        addr_d       = req0_addr;
                        wdata_d      = req0_wdata;
                        state_d      = S_ISSUE;
                    end
                    acc1: begin
                        owner_d      = 1'b1;
                        last_grant_d = 1'b1;
                        write_d      = req1_write;
                        addr_d       = req1_addr;
                        wdata_d      = req1_wdata;
                        state_d      = S_ISSUE;
                    end
                    default: ;
                endcase
            end
            S_ISSUE: begin
                mem_save = write_q;
                if (write_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = LAT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd1) begin
                    state_d = S_IDLE;
                    if (owner_q) begin
                        rdata1_d  = mem_rdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_rdata;
                        rvalid0_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 2'd0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
        end
    end
endmodule
